// File: rtl/life_controller.sv
// life_controller: sequencing controller for the 8x8 Game of Life datapath.
// Holds the current-generation grid, commits the datapath's next generation
// under load / run / pause / single-step control with a programmable
// generation period, counts generations and halts on extinction or a still
// life. Optional feature macro: LIFE_CTRL_OSC_DETECT_EN adds period-2
// oscillator detection (prev_grid register plus valid bit).
module life_controller #(
  parameter int PERIOD_W = 16,
  parameter int GEN_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [63:0]         seed,
  input  logic                run,
  input  logic                step,
  input  logic [PERIOD_W-1:0] period,
  input  logic [63:0]         grid_evolve,
  output logic [63:0]         grid,
  output logic [GEN_W-1:0]    generation,
  output logic [1:0]          state,
  output logic                extinct,
  output logic                stable,
  output logic                oscillating
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t              state_r;
  logic [63:0]         grid_r;
  logic [GEN_W-1:0]    gen_r;
  logic [PERIOD_W-1:0] presc_r;
  logic                extinct_r;
  logic                stable_r;

  logic                commit_s;
  logic                evolve_zero_s;
  logic                evolve_same_s;
  logic                evolve_osc_s;
  logic                halt_s;

  assign evolve_zero_s = (grid_evolve == 64'd0);
  assign evolve_same_s = (grid_evolve == grid_r);
  assign halt_s        = evolve_zero_s | evolve_same_s | evolve_osc_s;

  // Decide whether this edge commits the datapath result.
  always_comb begin
    commit_s = 1'b0;
    case (state_r)
      IDLE:    commit_s = step;
      RUN:     commit_s = run && (presc_r == period);
      HALT:    commit_s = 1'b0;
      default: commit_s = 1'b0;
    endcase
  end

  // Main sequencer: load beats halt detection, which beats step/run.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      grid_r    <= 64'd0;
      gen_r     <= {GEN_W{1'b0}};
      presc_r   <= {PERIOD_W{1'b0}};
      extinct_r <= 1'b0;
      stable_r  <= 1'b0;
    end else if (load) begin
      state_r   <= IDLE;
      grid_r    <= seed;
      gen_r     <= {GEN_W{1'b0}};
      presc_r   <= {PERIOD_W{1'b0}};
      extinct_r <= 1'b0;
      stable_r  <= 1'b0;
    end else if (commit_s) begin
      // The commit happens even when halting, so the final pattern is kept.
      grid_r  <= grid_evolve;
      presc_r <= {PERIOD_W{1'b0}};
      if (gen_r != {GEN_W{1'b1}}) begin
        gen_r <= gen_r + {{(GEN_W-1){1'b0}}, 1'b1};
      end
      if (halt_s) begin
        state_r <= HALT;
      end
      if (evolve_zero_s) begin
        extinct_r <= 1'b1;
      end else if (evolve_same_s) begin
        stable_r <= 1'b1;
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (run) begin
            state_r <= RUN;
            presc_r <= {PERIOD_W{1'b0}};
          end
        end
        RUN: begin
          if (!run) begin
            state_r <= IDLE;
            presc_r <= {PERIOD_W{1'b0}};
          end else begin
            // Lowering period below the count lets this wrap before matching.
            presc_r <= presc_r + {{(PERIOD_W-1){1'b0}}, 1'b1};
          end
        end
        HALT:    state_r <= HALT;
        default: state_r <= IDLE;
      endcase
    end
  end

`ifdef LIFE_CTRL_OSC_DETECT_EN
  logic [63:0] prev_grid_r;
  logic        prev_valid_r;
  logic        osc_r;

  // A period-2 cycle returns to the grid seen two generations ago.
  assign evolve_osc_s = prev_valid_r && (grid_evolve == prev_grid_r) && !evolve_same_s;

  // Remember the previous generation and flag a period-2 oscillator.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_grid_r  <= 64'd0;
      prev_valid_r <= 1'b0;
      osc_r        <= 1'b0;
    end else if (load) begin
      prev_grid_r  <= 64'd0;
      prev_valid_r <= 1'b0;
      osc_r        <= 1'b0;
    end else if (commit_s) begin
      prev_grid_r  <= grid_r;
      prev_valid_r <= 1'b1;
      if (!evolve_zero_s && !evolve_same_s && evolve_osc_s) begin
        osc_r <= 1'b1;
      end
    end
  end

  assign oscillating = osc_r;
`else
  assign evolve_osc_s = 1'b0;
  assign oscillating  = 1'b0;
`endif

  assign grid       = grid_r;
  assign generation = gen_r;
  assign state      = state_r;
  assign extinct    = extinct_r;
  assign stable     = stable_r;

endmodule

// File: tb/tb_life_controller.sv
// tb_life_controller: randomized and directed bench for life_controller.
// The bench supplies the Life datapath itself and predicts every output with
// a mode/countdown reference model built from the controller's rules.
module tb_life_controller;

  logic        clk;
  logic        reset;
  logic        load;
  logic [63:0] seed;
  logic        run;
  logic        step;
  logic [15:0] period;
  logic [63:0] grid_evolve;
  logic [63:0] grid;
  logic [15:0] generation;
  logic [1:0]  state;
  logic        extinct;
  logic        stable;
  logic        oscillating;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [63:0] m_grid;
  int          m_gen;
  int          m_mode;   // 0 idle, 1 running, 2 halted
  int          m_left;   // run edges still to wait before the next commit
  bit          m_ext, m_stb, m_osc;
  logic [63:0] m_prev;
  bit          m_prev_valid;

  life_controller #(.PERIOD_W(16), .GEN_W(16)) dut (
    .clk(clk), .reset(reset), .load(load), .seed(seed), .run(run),
    .step(step), .period(period), .grid_evolve(grid_evolve), .grid(grid),
    .generation(generation), .state(state), .extinct(extinct),
    .stable(stable), .oscillating(oscillating)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Conway's rule on an 8x8 board with dead cells beyond the border.
  function automatic logic [63:0] life_next(input logic [63:0] g);
    logic [63:0] r;
    r = 64'd0;
    for (int row = 0; row < 8; row++) begin
      for (int col = 0; col < 8; col++) begin
        int n;
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if ((dr != 0 || dc != 0) && row + dr >= 0 && row + dr < 8 &&
                col + dc >= 0 && col + dc < 8) begin
              n += int'(g[(row + dr) * 8 + col + dc]);
            end
          end
        end
        if (g[row * 8 + col]) r[row * 8 + col] = (n == 2 || n == 3);
        else                  r[row * 8 + col] = (n == 3);
      end
    end
    return r;
  endfunction

  always_comb grid_evolve = life_next(grid);

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_grid = 64'd0; m_gen = 0; m_mode = 0; m_left = 0;
    m_ext = 0; m_stb = 0; m_osc = 0; m_prev = 64'd0; m_prev_valid = 0;
  endtask

  // Apply the controller rules for one rising edge using the driven inputs.
  task automatic model_edge();
    logic [63:0] nxt;
    bit do_commit;
    nxt = life_next(m_grid);
    do_commit = 0;
    if (load) begin
      m_grid = seed; m_gen = 0; m_mode = 0; m_left = 0;
      m_ext = 0; m_stb = 0; m_osc = 0; m_prev = 64'd0; m_prev_valid = 0;
    end else begin
      if (m_mode == 0) begin
        if (step) do_commit = 1;
        else if (run) begin m_mode = 1; m_left = int'(period); end
      end else if (m_mode == 1) begin
        if (!run) m_mode = 0;
        else if (m_left == 0) do_commit = 1;
        else m_left--;
      end
      if (do_commit) begin
        if (nxt == 64'd0) begin m_ext = 1; m_mode = 2; end
        else if (nxt == m_grid) begin m_stb = 1; m_mode = 2; end
`ifdef LIFE_CTRL_OSC_DETECT_EN
        else if (m_prev_valid && nxt == m_prev) begin m_osc = 1; m_mode = 2; end
`endif
        m_prev = m_grid; m_prev_valid = 1;
        m_grid = nxt;
        if (m_gen != 65535) m_gen++;
        m_left = int'(period);
      end
    end
  endtask

  task automatic compare_all();
    check_val("grid", grid, m_grid);
    check_val("generation", 64'(generation), 64'(m_gen));
    check_val("state", 64'(state), 64'(m_mode));
    check_val("extinct", 64'(extinct), 64'(m_ext));
    check_val("stable", 64'(stable), 64'(m_stb));
    check_val("oscillating", 64'(oscillating), 64'(m_osc));
  endtask

  // One clock: drive at the falling edge, model the rising edge, check 1 ns later.
  task automatic cyc(input bit l, input logic [63:0] s, input bit r, input bit st);
    load = l; seed = s; run = r; step = st;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic async_reset();
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_val("rst_grid", grid, 64'd0);
    check_val("rst_gen", 64'(generation), 64'd0);
    check_val("rst_state", 64'(state), 64'd0);
    compare_all();
    @(negedge clk);
    reset = 1'b1;
  endtask

  logic [63:0] pats [0:4];

  initial begin
    pats[0] = 64'h0000_0000_0000_0E00;  // blinker
    pats[1] = 64'h0000_0000_0000_0303;  // block
    pats[2] = 64'h0000_0000_0000_0702;  // glider fragment
    pats[3] = 64'h0000_0000_0800_0000;  // single cell
    pats[4] = 64'h0000_0018_1800_0000;  // centered block

    reset = 1'b0; load = 1'b0; seed = 64'd0; run = 1'b0; step = 1'b0;
    period = 16'd0;
    model_reset();
    #2;
    compare_all();
    @(negedge clk);
    reset = 1'b1;

    // reset mid-run with period 3
    period = 16'd3;
    cyc(1, pats[0], 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 64'd0, 1, 0);
    async_reset();

    // blinker single steps
    cyc(1, pats[0], 0, 0);
    cyc(0, 64'd0, 0, 1);
    check_val("blink_s1", grid, 64'h0000_0000_0004_0404);
    cyc(0, 64'd0, 0, 1);
    check_val("blink_s2", grid, 64'h0000_0000_0000_0E00);
    check_val("blink_gen", 64'(generation), 64'd2);
    check_val("blink_idle", 64'(state), 64'd0);

    // step and run together: step wins, run re-sampled next edge
    cyc(0, 64'd0, 1, 1);
    check_val("step_wins", 64'(state), 64'd0);
    cyc(0, 64'd0, 0, 0);

    // period 2 run, then drop run mid-count
    period = 16'd2;
    for (int i = 0; i < 8; i++) cyc(0, 64'd0, 1, 0);
    cyc(0, 64'd0, 0, 0);
    check_val("drop_run", 64'(state), 64'd0);
    for (int i = 0; i < 4; i++) cyc(0, 64'd0, 1, 0);

    // 2x2 block becomes stable
    period = 16'd0;
    cyc(1, pats[1], 0, 0);
    cyc(0, 64'd0, 1, 0);
    cyc(0, 64'd0, 1, 0);
    check_val("blk_stable", 64'(stable), 64'd1);
    check_val("blk_halt", 64'(state), 64'd2);
    check_val("blk_gen", 64'(generation), 64'd1);
    check_val("blk_grid", grid, 64'h303);
    for (int i = 0; i < 3; i++) cyc(0, 64'd0, 1, 1);

    // single cell dies
    cyc(1, pats[3], 0, 0);
    cyc(0, 64'd0, 0, 1);
    check_val("cell_grid", grid, 64'd0);
    check_val("cell_ext", 64'(extinct), 64'd1);
    check_val("cell_stable", 64'(stable), 64'd0);
    check_val("cell_halt", 64'(state), 64'd2);
    cyc(1, pats[0], 0, 0);
    check_val("reload_ext", 64'(extinct), 64'd0);
    check_val("reload_idle", 64'(state), 64'd0);

    // free-running blinker
    for (int i = 0; i < 11; i++) cyc(0, 64'd0, 1, 0);
`ifdef LIFE_CTRL_OSC_DETECT_EN
    check_val("osc_flag", 64'(oscillating), 64'd1);
    check_val("osc_halt", 64'(state), 64'd2);
    check_val("osc_gen", 64'(generation), 64'd2);
`else
    check_val("osc_flag", 64'(oscillating), 64'd0);
    check_val("osc_run", 64'(state), 64'd1);
    check_val("osc_gen", 64'(generation), 64'd10);
`endif

    // randomized stimulus
    for (int i = 0; i < 2000; i++) begin
      bit l, r, st;
      logic [63:0] s;
      l  = ($urandom_range(0, 29) == 0);
      r  = ($urandom_range(0, 3) != 0);
      st = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 1) == 0) s = pats[$urandom_range(0, 4)];
      else s = {$urandom, $urandom} & {$urandom, $urandom};
      if (l && m_mode != 1) period = 16'($urandom_range(0, 3));
      cyc(l, s, r, st);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
